// File: rtl/id_operand_stage.sv
// id_operand_stage
//   Decode-stage operand unit: holds the IF->ID pipeline register and the
//   architectural register file, and resolves both source operands of the
//   held entry against in-flight results (forwarding), a same-cycle
//   writeback (write-through) and the register file.
//
// Optional feature (macro DS_STALL_CNT_EN):
//   When defined, adds output stall_cnt[31:0], a saturating count of cycles in
//   which a held entry was stalled on an unready forwarding source.
//
// Ports
//   clk, reset                  clock; synchronous active-high reset
//   in_valid/in_allowin         upstream handshake
//   in_payload                  opaque payload carried to execute
//   in_rs1/in_rs2               source register indices
//   in_need_rs1/in_need_rs2     operand is consumed and must be hazard-checked
//   flush                       kill the held entry; wins over a same-cycle accept
//   out_valid/out_allowin       downstream handshake
//   out_payload                 latched payload
//   out_rs1_val/out_rs2_val     resolved operands
//   fwd_valid/we/ready/reg/data forwarding sources, index 0 = youngest
//   wb_we/wb_addr/wb_data       register file write port
//   stall_cnt                   (DS_STALL_CNT_EN only) stall cycle counter
//
// Handshake: a transfer happens on a side exactly in a cycle where both
//   valid and allowin are high at the clock edge. in_allowin is high when the
//   stage is empty or its entry leaves this cycle; out_valid is high only when
//   the entry is held and both operands are resolved.
module id_operand_stage #(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int NUM_FWD   = 2,
  parameter int PAYLOAD_W = 64,
  localparam int AW       = $clog2(NREG)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_allowin,
  input  logic [PAYLOAD_W-1:0]    in_payload,
  input  logic [AW-1:0]           in_rs1,
  input  logic [AW-1:0]           in_rs2,
  input  logic                    in_need_rs1,
  input  logic                    in_need_rs2,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_allowin,
  output logic [PAYLOAD_W-1:0]    out_payload,
  output logic [XLEN-1:0]         out_rs1_val,
  output logic [XLEN-1:0]         out_rs2_val,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [NUM_FWD-1:0]      fwd_we,
  input  logic [NUM_FWD-1:0]      fwd_ready,
  input  logic [NUM_FWD*AW-1:0]   fwd_reg,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data,
  input  logic                    wb_we,
  input  logic [AW-1:0]           wb_addr,
  input  logic [XLEN-1:0]         wb_data
`ifdef DS_STALL_CNT_EN
  ,
  output logic [31:0]             stall_cnt
`endif
);

  // Pipeline register
  logic                 valid_q, valid_d;
  logic [PAYLOAD_W-1:0] payload_q, payload_d;
  logic [AW-1:0]        rs1_q, rs1_d;
  logic [AW-1:0]        rs2_q, rs2_d;
  logic                 need_rs1_q, need_rs1_d;
  logic                 need_rs2_q, need_rs2_d;

  // Register file
  logic [XLEN-1:0]      rf_q [NREG];
  logic [XLEN-1:0]      rf_d [NREG];

  logic                 accept;
  logic                 ready_go;
  logic                 stall_rs1, stall_rs2;
  logic [XLEN-1:0]      rs1_val, rs2_val;

  // Returns {stall, value} for one operand. The youngest matching source
  // wins; older matches are shadowed even when the youngest is not ready.
  // r0 short-circuits everything so it can neither stall nor be bypassed.
  function automatic logic [XLEN:0] resolve_operand(
    input logic [AW-1:0]   rs,
    input logic            need,
    input logic [XLEN-1:0] rf_val
  );
    logic            found;
    logic [XLEN:0]   res;
    found = 1'b0;
    res   = {1'b0, rf_val};
    if (rs == '0) begin
      res = '0;
    end else begin
      if (wb_we && (wb_addr == rs)) begin
        res = {1'b0, wb_data};
      end
      for (int i = 0; i < NUM_FWD; i++) begin
        if (!found && need && fwd_valid[i] && fwd_we[i] &&
            (fwd_reg[i*AW +: AW] == rs)) begin
          found = 1'b1;
          res   = {!fwd_ready[i], fwd_data[i*XLEN +: XLEN]};
        end
      end
    end
    return res;
  endfunction

  always_comb begin
    {stall_rs1, rs1_val} = resolve_operand(rs1_q, need_rs1_q, rf_q[rs1_q]);
    {stall_rs2, rs2_val} = resolve_operand(rs2_q, need_rs2_q, rf_q[rs2_q]);
  end

  assign ready_go    = !(stall_rs1 || stall_rs2);
  assign out_valid   = valid_q && ready_go;
  assign in_allowin  = !valid_q || (out_allowin && ready_go);
  assign accept      = in_valid && in_allowin;
  assign out_payload = payload_q;
  assign out_rs1_val = rs1_val;
  assign out_rs2_val = rs2_val;

  // Next-state for the pipeline register. A flush drops both the held entry
  // and anything offered in the same cycle.
  always_comb begin
    valid_d    = valid_q;
    payload_d  = payload_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    need_rs1_d = need_rs1_q;
    need_rs2_d = need_rs2_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d    = 1'b1;
      payload_d  = in_payload;
      rs1_d      = in_rs1;
      rs2_d      = in_rs2;
      need_rs1_d = in_need_rs1;
      need_rs2_d = in_need_rs2;
    end else if (out_valid && out_allowin) begin
      valid_d = 1'b0;
    end
  end

  // Register file write; writes to r0 are discarded.
  always_comb begin
    rf_d = rf_q;
    if (wb_we && (wb_addr != '0)) begin
      rf_d[wb_addr] = wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Datapath state is deliberately not reset.
  always_ff @(posedge clk) begin
    payload_q  <= payload_d;
    rs1_q      <= rs1_d;
    rs2_q      <= rs2_d;
    need_rs1_q <= need_rs1_d;
    need_rs2_q <= need_rs2_d;
    rf_q       <= rf_d;
  end

`ifdef DS_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (valid_q && !ready_go && !flush && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_operand_stage.sv
module tb_id_operand_stage;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NF   = 2;
  localparam int PW   = 64;

  logic                clk;
  logic                reset;
  logic                in_valid;
  logic                in_allowin;
  logic [PW-1:0]       in_payload;
  logic [AW-1:0]       in_rs1, in_rs2;
  logic                in_need_rs1, in_need_rs2;
  logic                flush;
  logic                out_valid;
  logic                out_allowin;
  logic [PW-1:0]       out_payload;
  logic [XLEN-1:0]     out_rs1_val, out_rs2_val;
  logic [NF-1:0]       fwd_valid, fwd_we, fwd_ready;
  logic [NF*AW-1:0]    fwd_reg;
  logic [NF*XLEN-1:0]  fwd_data;
  logic                wb_we;
  logic [AW-1:0]       wb_addr;
  logic [XLEN-1:0]     wb_data;
`ifdef DS_STALL_CNT_EN
  logic [31:0]         stall_cnt;
`endif

  id_operand_stage dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_allowin  (in_allowin),
    .in_payload  (in_payload),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .in_need_rs1 (in_need_rs1),
    .in_need_rs2 (in_need_rs2),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_allowin (out_allowin),
    .out_payload (out_payload),
    .out_rs1_val (out_rs1_val),
    .out_rs2_val (out_rs2_val),
    .fwd_valid   (fwd_valid),
    .fwd_we      (fwd_we),
    .fwd_ready   (fwd_ready),
    .fwd_reg     (fwd_reg),
    .fwd_data    (fwd_data),
    .wb_we       (wb_we),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data)
`ifdef DS_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [PW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int exp_stall = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Payload monitor: every entry leaving the stage must be the oldest expected one.
  always @(negedge clk) begin
    if (reset === 1'b0 && out_valid === 1'b1 && out_allowin === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("payload_unexpected", out_payload, 64'h0);
      end else begin
        check("payload", out_payload, exp_q.pop_front());
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid    = 1'b0;
    in_payload  = '0;
    in_rs1      = '0;
    in_rs2      = '0;
    in_need_rs1 = 1'b0;
    in_need_rs2 = 1'b0;
    flush       = 1'b0;
    fwd_valid   = '0;
    fwd_we      = '0;
    fwd_ready   = '0;
    fwd_reg     = '0;
    fwd_data    = '0;
    wb_we       = 1'b0;
    wb_addr     = '0;
    wb_data     = '0;
  endtask

  task automatic send(input logic [PW-1:0] p, input int rs1, input int rs2, input int n1, input int n2);
    in_valid    = 1'b1;
    in_payload  = p;
    in_rs1      = AW'(rs1);
    in_rs2      = AW'(rs2);
    in_need_rs1 = (n1 != 0);
    in_need_rs2 = (n2 != 0);
  endtask

  // Vector table
  typedef struct {
    int unsigned rs1, rs2, need1, need2;
    int unsigned fv, fwe, frdy, fr0, fr1, fd0, fd1;
    int unsigned wbwe, wba, wbd;
    int unsigned ev, e1, e2;
  } vec_t;

  vec_t vecs[12];

  localparam logic [PW-1:0] P_LU = 64'h1111_2222_3333_0001;
  localparam logic [PW-1:0] P_A  = 64'hAAAA_0000_0000_000A;
  localparam logic [PW-1:0] P_B  = 64'hBBBB_0000_0000_000B;
  localparam logic [PW-1:0] P_C  = 64'hCCCC_0000_0000_000C;
  localparam logic [PW-1:0] P_D  = 64'hDDDD_0000_0000_000D;
  localparam logic [PW-1:0] P_E  = 64'hEEEE_0000_0000_000E;

  initial begin
    // Register file image after preload: r[i] = 0x0100_0000 | i, except r5 = 0x1234.
    //               rs1 rs2 n1 n2  fv fwe frdy fr0 fr1 fd0      fd1      wbwe wba wbd      ev e1           e2
    vecs[0]  = '{  1,  2, 1, 1,  0,  0,  0,   0,  0, 0,       0,       0,   0,  0,       1, 32'h01000001, 32'h01000002};
    vecs[1]  = '{  1,  2, 1, 1,  1,  1,  1,   1,  0, 'hAAAA,  0,       0,   0,  0,       1, 'hAAAA,       32'h01000002};
    vecs[2]  = '{  3,  3, 1, 1,  3,  3,  3,   3,  3, 'hAAAA,  'hBBBB,  0,   0,  0,       1, 'hAAAA,       'hAAAA};
    vecs[3]  = '{  4,  1, 1, 1,  3,  2,  2,   4,  4, 'hDDDD,  'hCCCC,  0,   0,  0,       1, 'hCCCC,       32'h01000001};
    vecs[4]  = '{  5,  2, 0, 1,  1,  1,  0,   5,  0, 'hEEEE,  0,       0,   0,  0,       1, 'h1234,       32'h01000002};
    vecs[5]  = '{  1,  5, 1, 1,  1,  1,  0,   5,  0, 'hEEEE,  0,       0,   0,  0,       0, 0,            0};
    vecs[6]  = '{  6,  2, 1, 1,  0,  1,  0,   6,  0, 'hEEEE,  0,       0,   0,  0,       1, 32'h01000006, 32'h01000002};
    vecs[7]  = '{  0,  0, 1, 1,  1,  1,  0,   0,  0, 'hDEAD,  0,       1,   0,  'hFFFF,  1, 0,            0};
    vecs[8]  = '{  9, 10, 1, 1,  0,  0,  0,   0,  0, 0,       0,       1,   9,  'h77,    1, 'h77,         32'h0100000A};
    vecs[9]  = '{ 11,  2, 1, 1,  3,  3,  1,  11, 11, 'h1111,  'h9999,  0,   0,  0,       1, 'h1111,       32'h01000002};
    vecs[10] = '{ 12,  1, 1, 1,  1,  1,  1,  12,  0, 'h2222,  0,       1,  12,  'h3333,  1, 'h2222,       32'h01000001};
    vecs[11] = '{ 12,  9, 1, 1,  1,  1,  1,  13,  0, 'h4444,  0,       0,   0,  0,       1, 'h3333,       'h77};

    // Reset held two cycles
    idle_inputs();
    out_allowin = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_in_allowin", 64'(in_allowin), 64'(1));
`ifdef DS_STALL_CNT_EN
    check("reset_stall_cnt", 64'(stall_cnt), 64'(0));
`endif
    reset = 1'b0;

    // Preload register file through the writeback port
    for (int r = 1; r < 32; r++) begin
      step();
      wb_we   = 1'b1;
      wb_addr = AW'(r);
      wb_data = (r == 5) ? 32'h0000_1234 : (32'h0100_0000 | 32'(r));
    end
    step();
    wb_we = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 12; i++) begin
      vec_t v;
      v = vecs[i];
      step();
      idle_inputs();
      out_allowin = 1'b0;
      send(64'hC0DE_0000_0000_0000 + 64'(i), int'(v.rs1), int'(v.rs2), int'(v.need1), int'(v.need2));
      exp_q.push_back(64'hC0DE_0000_0000_0000 + 64'(i));
      step();
      in_valid    = 1'b0;
      out_allowin = 1'b1;
      fwd_valid   = NF'(v.fv);
      fwd_we      = NF'(v.fwe);
      fwd_ready   = NF'(v.frdy);
      fwd_reg     = {AW'(v.fr1), AW'(v.fr0)};
      fwd_data    = {XLEN'(v.fd1), XLEN'(v.fd0)};
      wb_we       = (v.wbwe != 0);
      wb_addr     = AW'(v.wba);
      wb_data     = XLEN'(v.wbd);
      @(negedge clk);
      check($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(v.ev));
      if (v.ev != 0) begin
        check($sformatf("vec%0d_rs1", i), 64'(out_rs1_val), 64'(v.e1));
        check($sformatf("vec%0d_rs2", i), 64'(out_rs2_val), 64'(v.e2));
      end else begin
        check($sformatf("vec%0d_in_allowin", i), 64'(in_allowin), 64'(0));
        exp_stall++;
        step();
        fwd_valid = '0;
        wb_we     = 1'b0;
      end
    end

    // Load-use: youngest source not ready for two cycles
    step();
    idle_inputs();
    out_allowin = 1'b0;
    send(P_LU, 1, 7, 0, 1);
    exp_q.push_back(P_LU);
    step();
    in_valid    = 1'b0;
    out_allowin = 1'b1;
    fwd_valid   = 2'b01;
    fwd_we      = 2'b01;
    fwd_ready   = 2'b00;
    fwd_reg     = {5'd0, 5'd7};
    fwd_data    = '0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("loaduse_c%0d_out_valid", c), 64'(out_valid), 64'(0));
      check($sformatf("loaduse_c%0d_in_allowin", c), 64'(in_allowin), 64'(0));
      exp_stall++;
      step();
    end
    fwd_ready = 2'b01;
    fwd_data  = {32'h0, 32'h55};
    @(negedge clk);
    check("loaduse_release_out_valid", 64'(out_valid), 64'(1));
    check("loaduse_release_rs2", 64'(out_rs2_val), 64'h55);
`ifdef DS_STALL_CNT_EN
    check("loaduse_stall_cnt", 64'(stall_cnt), 64'(exp_stall));
`endif

    // Flush against a held entry while an accept is offered
    step();
    idle_inputs();
    out_allowin = 1'b0;
    send(P_A, 1, 2, 1, 1);
    exp_q.push_back(P_A);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_held_out_valid", 64'(out_valid), 64'(1));
    step();
    flush = 1'b1;
    send(P_B, 3, 4, 1, 1);
    void'(exp_q.pop_back());
    step();
    idle_inputs();
    @(negedge clk);
    check("flush_a_out_valid", 64'(out_valid), 64'(0));
    check("flush_a_in_allowin", 64'(in_allowin), 64'(1));
    check("flush_a_payload", out_payload, P_A);

    // Flush against an accept into an empty stage
    step();
    flush = 1'b1;
    send(P_C, 3, 4, 1, 1);
    @(negedge clk);
    check("flush_b_in_allowin", 64'(in_allowin), 64'(1));
    step();
    idle_inputs();
    @(negedge clk);
    check("flush_b_out_valid", 64'(out_valid), 64'(0));
    check("flush_b_payload", out_payload, P_A);

    // Backpressure with a write-through during the hold
    step();
    idle_inputs();
    out_allowin = 1'b0;
    send(P_D, 9, 2, 1, 1);
    exp_q.push_back(P_D);
    step();
    send(P_E, 9, 3, 1, 1);
    @(negedge clk);
    check("bp_h0_out_valid", 64'(out_valid), 64'(1));
    check("bp_h0_in_allowin", 64'(in_allowin), 64'(0));
    check("bp_h0_payload", out_payload, P_D);
    check("bp_h0_rs1", 64'(out_rs1_val), 64'h77);
    step();
    wb_we   = 1'b1;
    wb_addr = 5'd9;
    wb_data = 32'h99;
    @(negedge clk);
    check("bp_h1_in_allowin", 64'(in_allowin), 64'(0));
    check("bp_h1_payload", out_payload, P_D);
    check("bp_h1_rs1_writethrough", 64'(out_rs1_val), 64'h99);
    step();
    wb_we = 1'b0;
    @(negedge clk);
    check("bp_h2_in_allowin", 64'(in_allowin), 64'(0));
    check("bp_h2_payload", out_payload, P_D);
    check("bp_h2_rs1", 64'(out_rs1_val), 64'h99);
    step();
    out_allowin = 1'b1;
    exp_q.push_back(P_E);
    @(negedge clk);
    check("bp_release_in_allowin", 64'(in_allowin), 64'(1));
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_out_valid", 64'(out_valid), 64'(1));
    check("bp_next_rs1", 64'(out_rs1_val), 64'h99);
    check("bp_next_rs2", 64'(out_rs2_val), 64'h0100_0003);

    step();
    idle_inputs();
    repeat (3) step();
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net against a hung run
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
